// File: rtl/hit_sprite_pkg.sv
// Shared types and constants for the hit-sprite drawer.
//   hit_state_t : display FSM states (IDLE, ARMED, SHOW)
//   SCREEN_W/H  : visible raster size
//   ROM_AW      : sprite ROM address width
package hit_sprite_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHOW  = 2'd2
    } hit_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int ROM_AW   = 19;

endpackage

// File: rtl/hit_sprite_timer.sv
// Hit-sprite display timer: FSM, pending/displayed position registers and
// frame counter. The displayed position only moves on frame_start, so the
// sprite never tears mid-frame.
// Optional build macro: HIT_SPRITE_BLINK_EN (blink during the final quarter).
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   hit_pulse          1-cycle hit event; hit_x/hit_y sampled with it
//   frame_start        1-cycle pulse at start of vertical blank
//   state              current FSM state (debug + activity decode)
//   disp_x, disp_y     top-left of the sprite currently displayed
//   blank              suppress opaque pixels this cycle (blink phase)
module hit_sprite_timer
    import hit_sprite_pkg::*;
#(
    parameter int DISPLAY_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hit_pulse,
    input  logic [9:0] hit_x,
    input  logic [9:0] hit_y,
    input  logic       frame_start,
    output hit_state_t state,
    output logic [9:0] disp_x,
    output logic [9:0] disp_y,
    output logic       blank
);

    hit_state_t state_n;
    logic [9:0] pend_x, pend_y, pend_x_n, pend_y_n;
    logic [9:0] disp_x_n, disp_y_n;
    logic [7:0] cnt, cnt_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pend_x <= '0;
            pend_y <= '0;
            disp_x <= '0;
            disp_y <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_n;
            pend_x <= pend_x_n;
            pend_y <= pend_y_n;
            disp_x <= disp_x_n;
            disp_y <= disp_y_n;
            cnt    <= cnt_n;
        end
    end

    // A hit always takes priority over frame_start in the same cycle: the
    // new position is captured and promotion waits for the next frame.
    always_comb begin
        state_n  = state;
        pend_x_n = pend_x;
        pend_y_n = pend_y;
        disp_x_n = disp_x;
        disp_y_n = disp_y;
        cnt_n    = cnt;
        case (state)
            IDLE: begin
                if (hit_pulse) begin
                    state_n  = ARMED;
                    pend_x_n = hit_x;
                    pend_y_n = hit_y;
                end
            end
            ARMED: begin
                if (hit_pulse) begin
                    pend_x_n = hit_x;
                    pend_y_n = hit_y;
                end else if (frame_start) begin
                    state_n  = SHOW;
                    disp_x_n = pend_x;
                    disp_y_n = pend_y;
                    cnt_n    = 8'(DISPLAY_FRAMES);
                end
            end
            SHOW: begin
                if (hit_pulse) begin
                    state_n  = ARMED;
                    pend_x_n = hit_x;
                    pend_y_n = hit_y;
                end else if (frame_start) begin
                    if (cnt == 8'd1) begin
                        state_n = IDLE;
                        cnt_n   = 8'd0;
                    end else begin
                        cnt_n = cnt - 8'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef HIT_SPRITE_BLINK_EN
    assign blank = (state == SHOW) && (cnt <= 8'(DISPLAY_FRAMES / 4)) && cnt[0];
`else
    assign blank = 1'b0;
`endif

endmodule

// File: rtl/hit_sprite_drawer.sv
// Hit-sprite drawer: shows the PerfectHit judgement sprite for a fixed number
// of frames after each hit, turning the raster position into a sprite ROM
// address and aligning the 1-cycle ROM latency (DrawX/DrawY -> pix_* is 2).
// Optional build macro: HIT_SPRITE_BLINK_EN (sprite blinks in its last quarter).
// Ports:
//   Clk, Reset_n         pixel clock, asynchronous active-low reset
//   hit_pulse/hit_x/y    hit event and sprite top-left for it
//   frame_start          start of vertical blank
//   DrawX, DrawY         raster position, valid when pixel_en
//   rom_addr / rom_data  sprite ROM read port (data one cycle after address)
//   pix_index            palette index for the colour mapper
//   pix_valid            pix_index is an opaque sprite pixel
//   active               sprite currently displayed
module hit_sprite_drawer
    import hit_sprite_pkg::*;
#(
    parameter int         SPR_W          = 136,
    parameter int         SPR_H          = 157,
    parameter int         DISPLAY_FRAMES = 30,
    parameter logic [7:0] TRANSP_IDX     = 8'h00
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              hit_pulse,
    input  logic [9:0]        hit_x,
    input  logic [9:0]        hit_y,
    input  logic              frame_start,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              pixel_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        pix_index,
    output logic              pix_valid,
    output logic              active
);

    localparam logic [10:0]       SPR_W11  = 11'(SPR_W);
    localparam logic [10:0]       SPR_H11  = 11'(SPR_H);
    localparam logic [10:0]       SCR_W11  = 11'(SCREEN_W);
    localparam logic [10:0]       SCR_H11  = 11'(SCREEN_H);
    localparam logic [ROM_AW-1:0] SPR_WA   = ROM_AW'(SPR_W);

    hit_state_t        state;
    logic [9:0]        disp_x, disp_y;
    logic              blank;
    logic [10:0]       dx, dy;
    logic              inbox, inbox_q;
    logic [ROM_AW-1:0] addr_c;

    hit_sprite_timer #(
        .DISPLAY_FRAMES(DISPLAY_FRAMES)
    ) u_timer (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .hit_pulse  (hit_pulse),
        .hit_x      (hit_x),
        .hit_y      (hit_y),
        .frame_start(frame_start),
        .state      (state),
        .disp_x     (disp_x),
        .disp_y     (disp_y),
        .blank      (blank)
    );

    assign active = (state == SHOW);

    // 11-bit offsets; the >= tests keep an underflowed offset out of the box,
    // and the screen bounds keep off-screen pixels from ever being requested.
    assign dx = {1'b0, DrawX} - {1'b0, disp_x};
    assign dy = {1'b0, DrawY} - {1'b0, disp_y};

    assign inbox = pixel_en && active
                && (DrawX >= disp_x) && (DrawY >= disp_y)
                && (dx < SPR_W11) && (dy < SPR_H11)
                && ({1'b0, DrawX} < SCR_W11) && ({1'b0, DrawY} < SCR_H11);

    assign addr_c = ROM_AW'(dy) * SPR_WA + ROM_AW'(dx);

    // Stage 1: ROM address, zero outside the sprite box.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr <= '0;
            inbox_q  <= 1'b0;
        end else begin
            rom_addr <= inbox ? addr_c : '0;
            inbox_q  <= inbox;
        end
    end

    // Stage 2: ROM data arrives; transparent index and blink phase are not opaque.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pix_index <= '0;
            pix_valid <= 1'b0;
        end else begin
            pix_index <= rom_data;
            pix_valid <= inbox_q && (rom_data != TRANSP_IDX) && !blank;
        end
    end

endmodule

// File: tb/tb_hit_sprite_drawer.sv
// Directed bench for hit_sprite_drawer built with DISPLAY_FRAMES = 3.
module tb_hit_sprite_drawer;
    import hit_sprite_pkg::*;

    logic        Clk;
    logic        Reset_n;
    logic        hit_pulse;
    logic [9:0]  hit_x, hit_y;
    logic        frame_start;
    logic [9:0]  DrawX, DrawY;
    logic        pixel_en;
    logic [18:0] rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  pix_index;
    logic        pix_valid;
    logic        active;

    int n_cmp = 0;
    int n_err = 0;

    hit_sprite_drawer #(
        .SPR_W(136),
        .SPR_H(157),
        .DISPLAY_FRAMES(3),
        .TRANSP_IDX(8'h00)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .hit_pulse  (hit_pulse),
        .hit_x      (hit_x),
        .hit_y      (hit_y),
        .frame_start(frame_start),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .pixel_en   (pixel_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .pix_index  (pix_index),
        .pix_valid  (pix_valid),
        .active     (active)
    );

    // clock
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic px(input int x, input int y, input logic en);
        DrawX    = 10'(x);
        DrawY    = 10'(y);
        pixel_en = en;
    endtask

    task automatic hit(input int x, input int y, input logic fs);
        hit_pulse   = 1'b1;
        hit_x       = 10'(x);
        hit_y       = 10'(y);
        frame_start = fs;
        tick();
        hit_pulse   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        Reset_n = 1'b0; hit_pulse = 1'b0; hit_x = '0; hit_y = '0;
        frame_start = 1'b0; DrawX = '0; DrawY = '0; pixel_en = 1'b0; rom_data = '0;
        #3;
        chk("rst_active", 32'(active), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_pix_valid", 32'(pix_valid), 0);
        chk("rst_pix_index", 32'(pix_index), 0);
        chk("rst_state", 32'(dut.u_timer.state), 32'(IDLE));
        tick(); tick();
        Reset_n = 1'b1;
        tick();

        // 1: hit at (100,50), first pixel
        hit(100, 50, 1'b0);
        chk("t1_state_armed", 32'(dut.u_timer.state), 32'(ARMED));
        chk("t1_active_armed", 32'(active), 0);
        frame();
        chk("t1_active_show", 32'(active), 1);
        px(100, 50, 1'b1);
        tick();
        chk("t1_addr_origin", 32'(rom_addr), 0);
        px(101, 51, 1'b1); rom_data = 8'h3C;
        tick();
        chk("t1_pix_index", 32'(pix_index), 32'h3C);
        chk("t1_pix_valid", 32'(pix_valid), 1);
        chk("t1_addr_101_51", 32'(rom_addr), 137);
        px(99, 50, 1'b1); rom_data = 8'h44;
        tick();
        chk("t1_pix_index2", 32'(pix_index), 32'h44);
        chk("t1_pix_valid2", 32'(pix_valid), 1);
        chk("t1_addr_left_out", 32'(rom_addr), 0);
        px(0, 0, 1'b0); rom_data = 8'h55;
        tick();
        chk("t1_valid_left_out", 32'(pix_valid), 0);
        chk("t1_pix_index3", 32'(pix_index), 32'h55);

        // 2: bottom-right corner and just outside it
        px(235, 206, 1'b1);
        tick();
        chk("t2_addr_last", 32'(rom_addr), 21351);
        px(236, 206, 1'b1); rom_data = 8'h11;
        tick();
        chk("t2_valid_last", 32'(pix_valid), 1);
        chk("t2_index_last", 32'(pix_index), 32'h11);
        chk("t2_addr_right_out", 32'(rom_addr), 0);
        px(235, 207, 1'b1); rom_data = 8'h22;
        tick();
        chk("t2_valid_right_out", 32'(pix_valid), 0);
        chk("t2_addr_below_out", 32'(rom_addr), 0);
        px(0, 0, 1'b0); rom_data = 8'h23;
        tick();
        chk("t2_valid_below_out", 32'(pix_valid), 0);

        // 3: 3-frame lifetime (promotion was frame 1)
        frame();
        chk("t3_active_f2", 32'(active), 1);
        frame();
        chk("t3_active_f3", 32'(active), 1);
        frame();
        chk("t3_active_f4", 32'(active), 0);
        chk("t3_state_idle", 32'(dut.u_timer.state), 32'(IDLE));
        px(101, 51, 1'b1); rom_data = 8'h3C;
        tick();
        chk("t3_addr_expired", 32'(rom_addr), 0);
        px(0, 0, 1'b0);
        tick();
        chk("t3_valid_expired", 32'(pix_valid), 0);

        // 4: clipped sprite at (600,400)
        hit(600, 400, 1'b0);
        frame();
        chk("t4_active", 32'(active), 1);
        px(639, 479, 1'b1);
        tick();
        chk("t4_addr_639_479", 32'(rom_addr), 10783);
        px(638, 479, 1'b1); rom_data = 8'h00;
        tick();
        chk("t4_valid_transp", 32'(pix_valid), 0);
        chk("t4_addr_638_479", 32'(rom_addr), 10782);
        px(640, 479, 1'b0); rom_data = 8'h05;
        tick();
        chk("t4_valid_opaque", 32'(pix_valid), 1);
        chk("t4_index_opaque", 32'(pix_index), 32'h05);
        chk("t4_addr_x640", 32'(rom_addr), 0);
        px(0, 0, 1'b0); rom_data = 8'h09;
        tick();
        chk("t4_valid_x640", 32'(pix_valid), 0);

        // 5: hit coincident with frame_start
        hit(10, 20, 1'b1);
        chk("t5_state_armed", 32'(dut.u_timer.state), 32'(ARMED));
        chk("t5_active_off", 32'(active), 0);
        chk("t5_disp_x_kept", 32'(dut.u_timer.disp_x), 600);
        hit(20, 30, 1'b1);
        chk("t5_no_promote", 32'(dut.u_timer.state), 32'(ARMED));
        hit(30, 40, 1'b0);
        chk("t5_still_armed", 32'(dut.u_timer.state), 32'(ARMED));
        frame();
        chk("t5_active_new", 32'(active), 1);
        chk("t5_disp_x_new", 32'(dut.u_timer.disp_x), 30);
        chk("t5_disp_y_new", 32'(dut.u_timer.disp_y), 40);

        // 6: asynchronous reset mid-SHOW
        px(31, 41, 1'b1);
        tick();
        chk("t6_addr_31_41", 32'(rom_addr), 137);
        px(32, 41, 1'b1); rom_data = 8'h07;
        tick();
        chk("t6_valid_pre", 32'(pix_valid), 1);
        chk("t6_addr_32_41", 32'(rom_addr), 138);
        Reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(pix_valid), 0);
        chk("t6_rst_active", 32'(active), 0);
        chk("t6_rst_addr", 32'(rom_addr), 0);
        chk("t6_rst_index", 32'(pix_index), 0);
        #2;
        Reset_n = 1'b1;
        px(0, 0, 1'b0);
        frame();
        chk("t6_idle_after", 32'(dut.u_timer.state), 32'(IDLE));
        chk("t6_active_after", 32'(active), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
